// File: rtl/vga_rx_monitor.sv
// VGA sink monitor: samples HS/VS/RGB, locks to frame timing, emits pixels and status.
// Define VGA_RX_CRC_EN to add a CRC-16-CCITT over each complete locked frame.
module vga_rx_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC_BP   = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs,
    input  logic        vs,
    input  logic [11:0] rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        err_pulse,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_crc
);

    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_END   = V_SYNC_BP + V_ACTIVE;

    localparam logic [11:0] H_SAT  = 12'(2 * H_TOTAL);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t      state;
    logic        hs_r, vs_r, hs_d, vs_d;
    logic [11:0] rgb_r;
    logic [11:0] hcnt, h_next;
    logic [9:0]  vcnt, v_next;
    logic [7:0]  good_frames;
    logic        line_err;
    logic        hs_fall, vs_fall;
    logic        line_bad, frame_bad, timeout, lock_err;
    logic        active, pix_hit;

    // Edge detectors reset low so a line already low at reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            rgb_r <= '0;
        end else begin
            hs_r  <= hs;
            vs_r  <= vs;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            rgb_r <= rgb;
        end
    end

    assign hs_fall = hs_d & ~hs_r;
    assign vs_fall = vs_d & ~vs_r;

    // h_next/v_next are the coordinates of the sample now sitting in rgb_r.
    always_comb begin
        h_next = hcnt;
        if (hs_fall) begin
            h_next = '0;
        end else if (hcnt != H_SAT) begin
            h_next = hcnt + 12'd1;
        end
        v_next = vcnt;
        if (vs_fall) begin
            v_next = '0;
        end else if (hs_fall && vcnt != 10'h3FF) begin
            v_next = vcnt + 10'd1;
        end
    end

    assign line_bad  = hs_fall && (hcnt != H_LAST);
    assign frame_bad = vs_fall && (vcnt != V_LAST);
    assign timeout   = (h_next == H_SAT) && (hcnt != H_SAT);
    assign lock_err  = line_bad | frame_bad | timeout;

    assign active = (h_next >= 12'(H_START)) && (h_next < 12'(H_END)) &&
                    (v_next >= 10'(V_SYNC_BP)) && (v_next < 10'(V_END));
    assign pix_hit = (state == LOCKED) && active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_next;
            vcnt <= v_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            good_frames <= '0;
            line_err    <= 1'b0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            err_pulse   <= 1'b0;
            frame_start <= vs_fall;
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state       <= MEASURE;
                        good_frames <= '0;
                        line_err    <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (vs_fall) begin
                        line_err <= 1'b0;
                        if (frame_bad || line_bad || line_err) begin
                            good_frames <= '0;
                        end else if (good_frames + 8'd1 >= 8'(LOCK_FRAMES)) begin
                            state       <= LOCKED;
                            locked      <= 1'b1;
                            good_frames <= '0;
                        end else begin
                            good_frames <= good_frames + 8'd1;
                        end
                    end else if (line_bad) begin
                        good_frames <= '0;
                        line_err    <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (lock_err) begin
                        err_pulse <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= pix_hit;
            if (pix_hit) begin
                pix_x   <= 10'(h_next - 12'(H_START));
                pix_y   <= 9'(v_next - 10'(V_SYNC_BP));
                pix_rgb <= rgb_r;
            end
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc, crc_nxt;

    function automatic logic [15:0] crc12(input logic [15:0] c,
                                          input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            if (r[15] ^ d[i]) begin
                r = {r[14:0], 1'b0} ^ 16'h1021;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    assign crc_nxt = crc12(crc, pix_rgb);

    // Running CRC only survives while locked; a bad edge discards the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
        end else if (state != LOCKED || lock_err) begin
            crc <= 16'hFFFF;
        end else if (vs_fall) begin
            frame_crc <= pix_valid ? crc_nxt : crc;
            crc       <= 16'hFFFF;
        end else if (pix_valid) begin
            crc <= crc_nxt;
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a shrunken raster (20x12 clocks per frame).
module tb_vga_rx_monitor;

    localparam int HS  = 4;
    localparam int HBP = 3;
    localparam int HA  = 8;
    localparam int HT  = 20;
    localparam int VT  = 12;
    localparam int VSB = 3;
    localparam int VA  = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hs, vs;
    logic [11:0] rgb;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_start, locked, err_pulse;
    logic [7:0]  err_cnt;
    logic [15:0] frame_crc;

    vga_rx_monitor #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_TOTAL(VT), .V_SYNC_BP(VSB), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .rgb(rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   nvec = 0, nmis = 0;
    int   nvalid = 0, nbad = 0, nerr = 0;
    int   first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    bit   seen = 1'b0;
    int   lock_rise = -1, fs_last = -1;
    bit   pat = 1'b0;
    logic locked_q = 1'b0;
    int   vf[$];
    logic [15:0] exp_crc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input logic [3:0] x,
                                            input logic [3:0] y);
        return pat ? {x, y, 4'h5} : 12'hF00;
    endfunction

    function automatic logic [11:0] pix_in(input int h, input int v);
        int x, y;
        if (h >= HS + HBP && h < HS + HBP + HA && v >= VSB && v < VSB + VA) begin
            x = h - (HS + HBP);
            y = v - VSB;
            return exp_rgb(4'(x), 4'(y));
        end
        return 12'h000;
    endfunction

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        logic [11:0] d;
        c = 16'hFFFF;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                d = {4'(x), 4'(y), 4'h5};
                for (int i = 11; i >= 0; i--) begin
                    if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
                    else c = {c[14:0], 1'b0};
                end
            end
        end
        return c;
    endfunction
`endif

    always @(negedge clk) begin
        if (pix_valid) begin
            if (!seen) begin
                first_x = int'(pix_x);
                first_y = int'(pix_y);
                seen = 1'b1;
            end
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            nvalid++;
            if (pix_rgb !== exp_rgb(pix_x[3:0], pix_y[3:0])) nbad++;
        end
        if (err_pulse) nerr++;
        if (frame_start) fs_last = cyc;
        if (locked && !locked_q) lock_rise = cyc;
        locked_q = locked;
    end

    task automatic send_lines(input int v0, input int v1, input int short_line);
        int len;
        for (int v = v0; v < v1; v++) begin
            len = (v == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                @(negedge clk);
                if (v == 0 && h == 0 && vs) vf.push_back(cyc);
                hs  = (h >= HS);
                vs  = (v >= 2);
                rgb = pix_in(h, v);
            end
        end
    endtask

    task automatic send_frame(input int short_line);
        send_lines(0, VT, short_line);
    endtask

    task automatic hold_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            hs = 1'b1;
            vs = 1'b1;
        end
    endtask

    task automatic clear_stats();
        nvalid = 0;
        nbad   = 0;
        nerr   = 0;
        seen   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        hs    = 1'b1;
        vs    = 1'b1;
        rgb   = '0;
        `ifdef VGA_RX_CRC_EN
        exp_crc = ref_crc();
        `else
        exp_crc = 16'h0000;
        `endif
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_errcnt", 32'(err_cnt), 0);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_crc", 32'(frame_crc), 0);

        @(negedge clk);
        rst_n = 1'b1;
        hold_idle(5);
        vf.delete();
        clear_stats();

        send_frame(-1);
        check("fs_latency", 32'(fs_last - vf[0]), 2);
        send_frame(-1);
        check("unlocked_valid", 32'(nvalid), 0);
        check("pre_lock", 32'(locked), 0);
        send_frame(-1);
        check("lock_latency", 32'(lock_rise - vf[2]), 2);
        check("locked", 32'(locked), 1);

        clear_stats();
        send_frame(-1);
        check("pix_count", 32'(nvalid), HA * VA);
        check("pix_bad_f00", 32'(nbad), 0);
        check("first_x", 32'(first_x), 0);
        check("first_y", 32'(first_y), 0);
        check("last_x", 32'(last_x), HA - 1);
        check("last_y", 32'(last_y), VA - 1);
        check("idle_valid", 32'(pix_valid), 0);
        check("hold_x", 32'(pix_x), HA - 1);
        check("hold_rgb", 32'(pix_rgb), 32'h00000F00);

        pat = 1'b1;
        clear_stats();
        send_frame(-1);
        send_frame(-1);
        check("crc_frame", 32'(frame_crc), 32'(exp_crc));
        send_frame(-1);
        check("crc_stable", 32'(frame_crc), 32'(exp_crc));
        check("pat_count", 32'(nvalid), 3 * HA * VA);
        check("pat_bad", 32'(nbad), 0);

        clear_stats();
        send_frame(5);
        check("short_pulses", 32'(nerr), 1);
        check("short_errcnt", 32'(err_cnt), 1);
        check("short_locked", 32'(locked), 0);
        send_frame(-1);
        send_frame(-1);
        check("relock_early", 32'(locked), 0);
        send_frame(-1);
        check("relock", 32'(locked), 1);

        clear_stats();
        hold_idle(50);
        check("tmo_pulses", 32'(nerr), 1);
        check("tmo_errcnt", 32'(err_cnt), 2);
        check("tmo_locked", 32'(locked), 0);
        hold_idle(60);
        check("tmo_once", 32'(nerr), 1);
        check("tmo_errcnt2", 32'(err_cnt), 2);
        check("tmo_valid", 32'(nvalid), 0);

        send_frame(-1);
        send_frame(-1);
        send_frame(-1);
        check("tmo_relock", 32'(locked), 1);
        clear_stats();
        send_lines(0, 5, -1);
        check("part_count", 32'(nvalid), 2 * HA);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(pix_valid), 0);
        check("mr_locked", 32'(locked), 0);
        check("mr_errcnt", 32'(err_cnt), 0);
        check("mr_x", 32'(pix_x), 0);
        check("mr_y", 32'(pix_y), 0);
        check("mr_rgb", 32'(pix_rgb), 0);
        check("mr_crc", 32'(frame_crc), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        send_lines(5, VT, -1);
        send_frame(-1);
        send_frame(-1);
        check("mr_no_valid", 32'(nvalid), 0);
        check("mr_unlocked", 32'(locked), 0);
        send_frame(-1);
        check("mr_relock", 32'(locked), 1);
        check("mr_count", 32'(nvalid), HA * VA);
        check("mr_bad", 32'(nbad), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Sink-side counterpart to vga_ctrl. Samples HS/VS/RGB at pixel clock, recovers timing, and locks to 640x480@60 framing.
- Emits per-pixel coordinates and colour, frame strobes and timing-error status.
- Used in simulation and on-board self-check: loops vga_ctrl outputs back to verify vga_screen_pic content and sync integrity.

Parameters:
- H_SYNC, 96, HS low width in clocks
- H_BP, 48, clocks from HS rising edge to first active pixel
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- V_SYNC_BP, 35, lines from VS fall to first active line (2 sync + 33 back porch)
- V_ACTIVE, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- clk  in  1  pixel clock, 25 MHz, same domain as vga_ctrl
- rst_n  in  1  asynchronous active-low reset
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- rgb  in  12  {R[3:0],G[3:0],B[3:0]}
- pix_valid  out  1  active pixel on pix_* this cycle (LOCKED only)
- pix_x  out  10  column 0..639
- pix_y  out  9  row 0..479
- pix_rgb  out  12  captured colour
- frame_start  out  1  one-cycle pulse on every VS falling edge
- locked  out  1  timing locked
- err_pulse  out  1  one-cycle pulse on any timing error
- err_cnt  out  8  saturating error count
- frame_crc  out  16  CRC of last complete locked frame

Behaviour:
- Reset: all outputs 0, state SEARCH, hcnt=0, vcnt=0, good_frames=0.
- Input register stage: hs_r, vs_r, rgb_r. Edges are detected against the previous hs_r/vs_r.
- hs_fall / vs_fall: a registered value goes 1->0.

Horizontal counter:
- hcnt is 12 bits. On hs_fall it is set to 0; otherwise it increments.
- It saturates at 2*H_TOTAL. Reaching 2*H_TOTAL in LOCKED is a timeout error.

Vertical counter:
- vcnt is 10 bits. On vs_fall it is set to 0.
- Otherwise it increments on each hs_fall.
- If vs_fall and hs_fall occur in the same cycle, vs_fall wins and vcnt=0.

Checks:
- Line check at each hs_fall: hcnt+1 must equal H_TOTAL.
- Frame check at each vs_fall: vcnt+1 must equal V_TOTAL.

FSM:
- SEARCH: wait for vs_fall, then go to MEASURE with good_frames=0. Line/frame mismatches here are ignored.
- MEASURE:
  - Any line mismatch: good_frames=0.
  - vs_fall with a passing frame check and no line error since the last vs_fall: good_frames++. When it reaches LOCK_FRAMES, go to LOCKED.
  - vs_fall with a failing frame check: good_frames=0.
  - MEASURE errors do not pulse err_pulse.
- LOCKED:
  - Any line mismatch, frame mismatch or timeout: err_pulse=1 for one cycle, err_cnt++ (saturates at 255), go to SEARCH, locked=0 on the next cycle.
  - locked=1 while in LOCKED.

Pixel output:
- Active when hcnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt is in [V_SYNC_BP, V_SYNC_BP+V_ACTIVE).
- pix_x = hcnt-(H_SYNC+H_BP); pix_y = vcnt-V_SYNC_BP.
- Latency: an rgb sample at input cycle t appears on pix_rgb with pix_valid at t+2.
- pix_valid=0 outside LOCKED. pix_x, pix_y and pix_rgb hold their last values when not valid.

Status outputs:
- frame_start pulses in every state, 2 cycles after the VS edge at the pins.
- err_cnt is cleared only by reset.
- Reset mid-frame returns the block to SEARCH. No partial-frame output follows.

Optional Feature:
- Macro VGA_RX_CRC_EN.
- Defined:
  - CRC-16-CCITT, poly 0x1021, init 0xFFFF, computed over pix_rgb of every valid pixel.
  - 12 bits per cycle, MSB first.
  - At vs_fall while LOCKED, frame_crc is loaded with the running value and the CRC is reinitialised to 0xFFFF.
  - Losing lock discards the running CRC; frame_crc keeps its last value.
- Undefined: no CRC logic; frame_crc is constant 16'h0000.

Test Plan:
- Ideal 640x480 timing, solid rgb=12'hF00, 3 frames:
  - locked rises 2 cycles after the third VS fall.
  - In frame 4: exactly 307200 pix_valid cycles, all with pix_rgb=F00.
  - First valid pixel is (0,0); last is (639,479).
- Single line shortened to 799 clocks while locked: err_pulse for one cycle, err_cnt=1, locked=0; relock after 2 good frames.
- HS held high 1600 clocks while locked: timeout error; err_cnt increments exactly once; state SEARCH.
- VS fall coincident with HS fall: vcnt=0 that cycle, pix_y of the first active line = 0.
- rgb = {pix_x[3:0], pix_y[3:0], 4'h5} pattern: every pix_rgb matches its pix_x/pix_y. With VGA_RX_CRC_EN, frame_crc matches the bench reference model and is stable across identical frames.
- Reset asserted mid-frame while locked: all outputs 0 immediately; no pix_valid until 2 full frames after release.
